videoconfig_writeback: RTL and testbench
========================================

Name: videoconfig_writeback

Overview:
Sits directly upstream of the power-on config retriever on the SRAM path, between the core's byte-wide SRAM port and the retriever's input side. It captures the boot video configuration (VGA on, scanlines off) when power-on reset ends, and lets hotkey pulses toggle both settings at runtime. With write-back compiled in, it persists the new config byte to SRAM word address 0x08FD5, low byte, so the next power-on retrieval picks it up. It takes the SRAM port only in idle slots and stalls the core while it owns the port.

Parameters:
CFG_ADDR, 21'h008FD5, 21-bit byte address of the config byte; bit 20 = 0 selects the low byte.
WE_CYCLES, 2, number of cycles sram_we_n is held low per write; legal range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pwon_reset  in  1  power-on reset from the retriever; high while the boot config is being fetched
vga_on_in  in  1  boot VGA setting from the retriever
scanlines_off_in  in  1  boot scanline setting from the retriever
toggle_vga  in  1  one-cycle pulse; flips VGA mode
toggle_scanlines  in  1  one-cycle pulse; flips scanlines
core_addr  in  21  core SRAM byte address
core_we_n  in  1  core write enable, active low
core_oe_n  in  1  core output enable, active low
core_data  in  8  core write data
core_idle  in  1  core is not using SRAM this cycle
core_wait  out  1  high while this block owns the SRAM port
sram_addr  out  21  to retriever sram_addr_in
sram_we_n  out  1  to retriever sram_we_n_in
sram_oe_n  out  1  to retriever sram_oe_n_in
sram_data_to_chip  out  8  to retriever write data
vga_on  out  1  live VGA enable
scanlines_off  out  1  live scanline disable
dirty  out  1  config changed and not yet written
busy  out  1  write-back FSM not in IDLE

Behaviour:
- Reset (rst_n low at a clk edge)
  - FSM goes to IDLE; cfg = 2'b00 (bit0 = vga, bit1 = scanlines on); captured = 0; dirty = 0; busy = 0; core_wait = 0.
  - Outputs after reset: vga_on = 0, scanlines_off = 1.
  - While rst_n is low, sram_we_n is forced to 1. The other SRAM outputs pass the core signals through.
- Capture
  - pwon_reset is registered each cycle.
  - At the first edge where the registered value is 1 and the current value is 0, cfg <= {~scanlines_off_in, vga_on_in} and captured <= 1.
  - Before capture, toggles are ignored.
- Outputs
  - vga_on = cfg[0]; scanlines_off = ~cfg[1]. Both are driven directly from registers.
  - They change one edge after the toggle is sampled.
- Toggles
  - toggle_vga flips cfg[0]; toggle_scanlines flips cfg[1]. Both in the same cycle flip both bits.
  - Any accepted toggle sets dirty.
  - A toggle in the same cycle dirty is cleared wins, so dirty stays 1.
- FSM: IDLE -> WAIT_SLOT -> SETUP -> WRITE -> HOLD -> IDLE
  - IDLE: if dirty, go to WAIT_SLOT next edge.
  - WAIT_SLOT: on an edge with core_idle = 1, go to SETUP. On entering SETUP, snapshot wdata = {6'b0, cfg} and clear dirty.
  - SETUP (1 cycle): sram_addr = CFG_ADDR, sram_oe_n = 1, sram_we_n = 1, data = wdata.
  - WRITE (WE_CYCLES cycles, down-counter): same outputs as SETUP but sram_we_n = 0.
  - HOLD (1 cycle): sram_we_n = 1; address and data still held.
  - Then IDLE. If dirty was re-set during the write, a new write follows from the updated cfg.
- Port ownership
  - core_wait = 1 in SETUP, WRITE and HOLD; busy = 1 in every state except IDLE.
  - Total ownership is WE_CYCLES + 2 cycles.
  - In IDLE and WAIT_SLOT, the SRAM outputs are a pure combinational passthrough of the core signals.
- pwon_reset rising while busy
  - Abort to IDLE with sram_we_n = 1 that cycle; clear dirty and captured; keep cfg.
  - A new capture occurs when pwon_reset falls.
- rst_n asserted mid-write: same as reset; the partial write is not retried.

Optional Feature:
CFG_WRITEBACK_EN
- Defined: full write-back FSM as above.
- Undefined:
  - The FSM is removed; busy and core_wait are tied to 0.
  - SRAM outputs are always passthrough, subject only to the rst_n we_n force.
  - dirty still tracks unsaved toggles and never clears except on reset or abort.

Test Plan:
- Boot capture: reset, then pwon_reset 1->0 with vga_on_in = 1, scanlines_off_in = 0 -> vga_on = 1, scanlines_off = 0, dirty = 0, no SRAM write.
- Toggle and write-back: after capture {vga = 1, scan = 1}, pulse toggle_vga with core_idle = 1.
  - Required: SETUP 2 edges after the pulse; sram_addr = 21'h008FD5; data = 8'h02; sram_we_n low exactly 2 cycles; core_wait high 4 cycles; dirty = 0 afterwards.
- Slot wait: dirty set, core_idle = 0 for 10 cycles -> FSM stays in WAIT_SLOT, passthrough intact, sram_we_n follows core_we_n; write starts on the first core_idle = 1 edge.
- Toggle during write: toggle_scanlines in the WRITE state -> first write keeps the snapshot value, dirty = 1 again, and a second write with the updated byte follows.
- Simultaneous toggles: both pulses in one cycle from cfg = 2'b01 -> cfg = 2'b10, exactly one write of 8'h02.
- Aborts and reset:
  - pwon_reset high during WRITE -> we_n high next cycle, busy = 0, and the new boot value is captured on the pwon_reset fall.
  - rst_n low during WRITE -> outputs at reset values.
  - Build without CFG_WRITEBACK_EN -> sram_we_n never driven low by this block.

Source files
------------

// File: rtl/videoconfig_writeback_if.sv
// SRAM byte-port bundle seen by videoconfig_writeback.
// It carries the core-side request signals and the retriever-facing SRAM signals.
interface videoconfig_writeback_if;
  logic [20:0] core_addr;
  logic        core_we_n;
  logic        core_oe_n;
  logic [7:0]  core_data;
  logic        core_idle;
  logic        core_wait;
  logic [20:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [7:0]  sram_data_to_chip;

  // master: the core plus the retriever; slave: the write-back block sitting between them
  modport master (
    output core_addr, core_we_n, core_oe_n, core_data, core_idle,
    input  core_wait, sram_addr, sram_we_n, sram_oe_n, sram_data_to_chip
  );

  modport slave (
    input  core_addr, core_we_n, core_oe_n, core_data, core_idle,
    output core_wait, sram_addr, sram_we_n, sram_oe_n, sram_data_to_chip
  );
endinterface

// File: rtl/videoconfig_writeback.sv
// Captures the boot video config, applies hotkey toggles, and persists the config byte to SRAM.
// The optional SRAM write-back FSM is enabled by defining CFG_WRITEBACK_EN.
module videoconfig_writeback #(
  parameter logic [20:0] CFG_ADDR  = 21'h008FD5,
  parameter int          WE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  videoconfig_writeback_if.slave  bus,
  input  logic                    pwon_reset,
  input  logic                    vga_on_in,
  input  logic                    scanlines_off_in,
  input  logic                    toggle_vga,
  input  logic                    toggle_scanlines,
  output logic                    vga_on,
  output logic                    scanlines_off,
  output logic                    dirty,
  output logic                    busy
);

  logic [1:0] cfg;
  logic       pwon_q;
  logic       captured;
  logic       capture;
  logic       toggle_acc;
  logic       clear_dirty;
  logic       abort;

  assign capture    = pwon_q & ~pwon_reset & ~captured;
  assign toggle_acc = captured & ~abort & (toggle_vga | toggle_scanlines);

  // A toggle landing on the same edge as the slot grab wins, so the newer cfg gets its own write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwon_q        <= 1'b0;
      cfg           <= 2'b00;
      captured      <= 1'b0;
      dirty         <= 1'b0;
      vga_on        <= 1'b0;
      scanlines_off <= 1'b1;
    end else begin
      pwon_q <= pwon_reset;
      if (capture) begin
        cfg           <= {~scanlines_off_in, vga_on_in};
        vga_on        <= vga_on_in;
        scanlines_off <= scanlines_off_in;
        captured      <= 1'b1;
      end else if (toggle_acc) begin
        cfg           <= cfg ^ {toggle_scanlines, toggle_vga};
        vga_on        <= cfg[0] ^ toggle_vga;
        scanlines_off <= ~(cfg[1] ^ toggle_scanlines);
      end
      if (abort) begin
        captured <= 1'b0;
        dirty    <= 1'b0;
      end else if (toggle_acc) begin
        dirty <= 1'b1;
      end else if (clear_dirty) begin
        dirty <= 1'b0;
      end
    end
  end

`ifdef CFG_WRITEBACK_EN
  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLOT,
    SETUP,
    WRITE,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] wdata;
  logic       own_we_n;
  logic       own;

  assign abort       = busy & pwon_reset & ~pwon_q;
  assign clear_dirty = (state == WAIT_SLOT) & bus.core_idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      wdata         <= 8'h00;
      own_we_n      <= 1'b1;
      busy          <= 1'b0;
      bus.core_wait <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      own_we_n      <= 1'b1;
      busy          <= 1'b0;
      bus.core_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dirty) begin
            state <= WAIT_SLOT;
            busy  <= 1'b1;
          end
        end
        WAIT_SLOT: begin
          if (bus.core_idle) begin
            state         <= SETUP;
            wdata         <= {6'b0, cfg};
            bus.core_wait <= 1'b1;
          end
        end
        SETUP: begin
          state    <= WRITE;
          cnt      <= 4'(WE_CYCLES - 1);
          own_we_n <= 1'b0;
        end
        WRITE: begin
          if (cnt == 4'd0) begin
            state    <= HOLD;
            own_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state         <= IDLE;
          busy          <= 1'b0;
          bus.core_wait <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          own_we_n      <= 1'b1;
          busy          <= 1'b0;
          bus.core_wait <= 1'b0;
        end
      endcase
    end
  end

  // Port is ours only in SETUP/WRITE/HOLD; everywhere else the core drives the SRAM directly.
  assign own                   = bus.core_wait & rst_n;
  assign bus.sram_addr         = own ? CFG_ADDR : bus.core_addr;
  assign bus.sram_oe_n         = own | bus.core_oe_n;
  assign bus.sram_data_to_chip = own ? wdata : bus.core_data;
  assign bus.sram_we_n         = (!rst_n || abort) ? 1'b1 : (own ? own_we_n : bus.core_we_n);
`else
  logic unused_wb;

  assign abort                 = 1'b0;
  assign clear_dirty           = 1'b0;
  assign busy                  = 1'b0;
  assign bus.core_wait         = 1'b0;
  assign bus.sram_addr         = bus.core_addr;
  assign bus.sram_oe_n         = bus.core_oe_n;
  assign bus.sram_data_to_chip = bus.core_data;
  assign bus.sram_we_n         = rst_n ? bus.core_we_n : 1'b1;
  assign unused_wb             = ^{bus.core_idle, CFG_ADDR, 4'(WE_CYCLES)};
`endif

endmodule

// File: tb/tb_videoconfig_writeback.sv
// Directed testbench for videoconfig_writeback; write-back scenarios run only when CFG_WRITEBACK_EN is defined.
module tb_videoconfig_writeback;
  localparam logic [20:0] CFG_ADDR = 21'h008FD5;
  localparam logic [20:0] DEF_ADDR = 21'h01ABCD;
  localparam logic [7:0]  DEF_DATA = 8'h5A;

  logic clk = 1'b0;
  logic rst_n;
  logic pwon_reset;
  logic vga_on_in;
  logic scanlines_off_in;
  logic toggle_vga;
  logic toggle_scanlines;
  logic vga_on;
  logic scanlines_off;
  logic dirty;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  videoconfig_writeback_if bus ();

  videoconfig_writeback #(
    .CFG_ADDR (CFG_ADDR),
    .WE_CYCLES(2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .pwon_reset      (pwon_reset),
    .vga_on_in       (vga_on_in),
    .scanlines_off_in(scanlines_off_in),
    .toggle_vga      (toggle_vga),
    .toggle_scanlines(toggle_scanlines),
    .vga_on          (vga_on),
    .scanlines_off   (scanlines_off),
    .dirty           (dirty),
    .busy            (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    pwon_reset       = 1'b1;
    toggle_vga       = 1'b0;
    toggle_scanlines = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic boot(input logic vga, input logic soff);
    vga_on_in        = vga;
    scanlines_off_in = soff;
    pwon_reset       = 1'b1;
    tick();
    pwon_reset = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic tv, input logic ts);
    toggle_vga       = tv;
    toggle_scanlines = ts;
    tick();
    toggle_vga       = 1'b0;
    toggle_scanlines = 1'b0;
  endtask

  task automatic test_reset();
    bus.core_we_n = 1'b0;
    rst_n         = 1'b0;
    pwon_reset    = 1'b1;
    repeat (2) tick();
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_vga_on: got %b expected 0", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_scanlines_off: got %b expected 1", scanlines_off); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_dirty: got %b expected 0", dirty); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (bus.core_wait !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_core_wait: got %b expected 0", bus.core_wait); end
    n_cmp++; if (bus.sram_we_n !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_we_forced: got %b expected 1", bus.sram_we_n); end
    n_cmp++; if (bus.sram_addr !== DEF_ADDR) begin n_bad++; $display("[TB] FAIL reset_addr_pass: got %h expected %h", bus.sram_addr, DEF_ADDR); end
    bus.core_we_n = 1'b1;
    rst_n         = 1'b1;
    tick();
  endtask

  task automatic test_boot_capture();
    int we_low;
    do_reset();
    pulse(1'b1, 1'b1);
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL precapture_vga_on: got %b expected 0", vga_on); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("[TB] FAIL precapture_dirty: got %b expected 0", dirty); end
    boot(1'b1, 1'b0);
    n_cmp++; if (vga_on !== 1'b1) begin n_bad++; $display("[TB] FAIL boot_vga_on: got %b expected 1", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b0) begin n_bad++; $display("[TB] FAIL boot_scanlines_off: got %b expected 0", scanlines_off); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("[TB] FAIL boot_dirty: got %b expected 0", dirty); end
    we_low = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.sram_we_n !== 1'b1) we_low++;
    end
    n_cmp++; if (we_low != 0) begin n_bad++; $display("[TB] FAIL boot_no_write: got %0d low cycles expected 0", we_low); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL boot_busy: got %b expected 0", busy); end
  endtask

  task automatic test_passthrough();
    bus.core_addr = 21'h012345;
    bus.core_we_n = 1'b0;
    bus.core_oe_n = 1'b1;
    bus.core_data = 8'hC3;
    #1;
    n_cmp++; if (bus.sram_addr !== 21'h012345) begin n_bad++; $display("[TB] FAIL pass_addr: got %h expected 012345", bus.sram_addr); end
    n_cmp++; if (bus.sram_we_n !== 1'b0) begin n_bad++; $display("[TB] FAIL pass_we_n: got %b expected 0", bus.sram_we_n); end
    n_cmp++; if (bus.sram_oe_n !== 1'b1) begin n_bad++; $display("[TB] FAIL pass_oe_n: got %b expected 1", bus.sram_oe_n); end
    n_cmp++; if (bus.sram_data_to_chip !== 8'hC3) begin n_bad++; $display("[TB] FAIL pass_data: got %h expected c3", bus.sram_data_to_chip); end
    bus.core_addr = DEF_ADDR;
    bus.core_we_n = 1'b1;
    bus.core_oe_n = 1'b0;
    bus.core_data = DEF_DATA;
    tick();
  endtask

  task automatic test_toggles();
    do_reset();
    boot(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL toggle_vga_on: got %b expected 0", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b0) begin n_bad++; $display("[TB] FAIL toggle_vga_scan: got %b expected 0", scanlines_off); end
    n_cmp++; if (dirty !== 1'b1) begin n_bad++; $display("[TB] FAIL toggle_dirty: got %b expected 1", dirty); end
    repeat (8) tick();
    pulse(1'b0, 1'b1);
    n_cmp++; if (scanlines_off !== 1'b1) begin n_bad++; $display("[TB] FAIL toggle_scan_off: got %b expected 1", scanlines_off); end
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL toggle_scan_vga: got %b expected 0", vga_on); end
    repeat (8) tick();
  endtask

`ifdef CFG_WRITEBACK_EN
  task automatic test_writeback();
    int setup_at, wait_cnt, we_low, oe_bad;
    logic [20:0] w_addr;
    logic [7:0]  w_data;
    do_reset();
    boot(1'b1, 1'b0);
    bus.core_idle = 1'b1;
    pulse(1'b1, 1'b0);
    setup_at = -1; wait_cnt = 0; we_low = 0; oe_bad = 0;
    w_addr = '0; w_data = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.core_wait === 1'b1) begin
        wait_cnt++;
        if (setup_at < 0) setup_at = i;
        if (bus.sram_oe_n !== 1'b1) oe_bad++;
      end
      if (bus.sram_we_n === 1'b0) begin
        we_low++;
        w_addr = bus.sram_addr;
        w_data = bus.sram_data_to_chip;
      end
    end
    n_cmp++; if (setup_at != 2) begin n_bad++; $display("[TB] FAIL wb_setup_edge: got %0d expected 2", setup_at); end
    n_cmp++; if (wait_cnt != 4) begin n_bad++; $display("[TB] FAIL wb_core_wait_cycles: got %0d expected 4", wait_cnt); end
    n_cmp++; if (we_low != 2) begin n_bad++; $display("[TB] FAIL wb_we_low_cycles: got %0d expected 2", we_low); end
    n_cmp++; if (w_addr !== CFG_ADDR) begin n_bad++; $display("[TB] FAIL wb_addr: got %h expected %h", w_addr, CFG_ADDR); end
    n_cmp++; if (w_data !== 8'h02) begin n_bad++; $display("[TB] FAIL wb_data: got %h expected 02", w_data); end
    n_cmp++; if (oe_bad != 0) begin n_bad++; $display("[TB] FAIL wb_oe_high: got %0d bad cycles expected 0", oe_bad); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("[TB] FAIL wb_dirty_after: got %b expected 0", dirty); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL wb_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_slot_wait();
    int follow_err, busy_lo, wait_hi;
    do_reset();
    boot(1'b1, 1'b0);
    bus.core_idle = 1'b0;
    pulse(1'b1, 1'b0);
    follow_err = 0; busy_lo = 0; wait_hi = 0;
    for (int i = 0; i < 10; i++) begin
      bus.core_we_n = i[0];
      tick();
      if (bus.sram_we_n !== i[0]) follow_err++;
      if (busy !== 1'b1) busy_lo++;
      if (bus.core_wait !== 1'b0) wait_hi++;
    end
    n_cmp++; if (follow_err != 0) begin n_bad++; $display("[TB] FAIL slot_we_follow: got %0d errors expected 0", follow_err); end
    n_cmp++; if (busy_lo != 0) begin n_bad++; $display("[TB] FAIL slot_busy: got %0d low cycles expected 0", busy_lo); end
    n_cmp++; if (wait_hi != 0) begin n_bad++; $display("[TB] FAIL slot_no_wait: got %0d high cycles expected 0", wait_hi); end
    bus.core_we_n = 1'b1;
    bus.core_idle = 1'b1;
    tick();
    n_cmp++; if (bus.core_wait !== 1'b1) begin n_bad++; $display("[TB] FAIL slot_setup_wait: got %b expected 1", bus.core_wait); end
    n_cmp++; if (bus.sram_addr !== CFG_ADDR) begin n_bad++; $display("[TB] FAIL slot_setup_addr: got %h expected %h", bus.sram_addr, CFG_ADDR); end
    n_cmp++; if (bus.sram_data_to_chip !== 8'h02) begin n_bad++; $display("[TB] FAIL slot_setup_data: got %h expected 02", bus.sram_data_to_chip); end
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL slot_done_busy: got %b expected 0", busy); end
  endtask

  task automatic test_toggle_during_write();
    int pulses;
    logic prev_we, dirty_mid;
    logic [7:0] wd [0:3];
    do_reset();
    boot(1'b1, 1'b0);
    bus.core_idle = 1'b1;
    pulse(1'b1, 1'b0);
    pulses = 0; prev_we = 1'b1; dirty_mid = 1'b0;
    for (int k = 0; k < 4; k++) wd[k] = 8'hFF;
    for (int i = 1; i <= 20; i++) begin
      toggle_scanlines = (i == 4);
      tick();
      toggle_scanlines = 1'b0;
      if (i == 4) dirty_mid = dirty;
      if (prev_we && bus.sram_we_n === 1'b0 && pulses < 4) begin
        wd[pulses] = bus.sram_data_to_chip;
        pulses++;
      end
      prev_we = bus.sram_we_n;
    end
    n_cmp++; if (dirty_mid !== 1'b1) begin n_bad++; $display("[TB] FAIL tdw_dirty_reset: got %b expected 1", dirty_mid); end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("[TB] FAIL tdw_write_count: got %0d expected 2", pulses); end
    n_cmp++; if (wd[0] !== 8'h02) begin n_bad++; $display("[TB] FAIL tdw_first_data: got %h expected 02", wd[0]); end
    n_cmp++; if (wd[1] !== 8'h00) begin n_bad++; $display("[TB] FAIL tdw_second_data: got %h expected 00", wd[1]); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("[TB] FAIL tdw_dirty_end: got %b expected 0", dirty); end
    n_cmp++; if (scanlines_off !== 1'b1) begin n_bad++; $display("[TB] FAIL tdw_scanlines_off: got %b expected 1", scanlines_off); end
  endtask

  task automatic test_simultaneous();
    int pulses;
    logic prev_we;
    logic [7:0] wd0;
    do_reset();
    boot(1'b1, 1'b1);
    bus.core_idle = 1'b1;
    pulse(1'b1, 1'b1);
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL sim_vga_on: got %b expected 0", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b0) begin n_bad++; $display("[TB] FAIL sim_scanlines_off: got %b expected 0", scanlines_off); end
    pulses = 0; prev_we = 1'b1; wd0 = 8'hFF;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (prev_we && bus.sram_we_n === 1'b0) begin
        if (pulses == 0) wd0 = bus.sram_data_to_chip;
        pulses++;
      end
      prev_we = bus.sram_we_n;
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL sim_write_count: got %0d expected 1", pulses); end
    n_cmp++; if (wd0 !== 8'h02) begin n_bad++; $display("[TB] FAIL sim_data: got %h expected 02", wd0); end
  endtask

  task automatic test_abort();
    int we_low;
    do_reset();
    boot(1'b1, 1'b0);
    bus.core_idle = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (3) tick();
    n_cmp++; if (bus.sram_we_n !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_pre_we: got %b expected 0", bus.sram_we_n); end
    vga_on_in        = 1'b1;
    scanlines_off_in = 1'b1;
    pwon_reset       = 1'b1;
    #1;
    n_cmp++; if (bus.sram_we_n !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_we_same_cycle: got %b expected 1", bus.sram_we_n); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (bus.sram_we_n !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_we_next: got %b expected 1", bus.sram_we_n); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_dirty: got %b expected 0", dirty); end
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_cfg_kept: got %b expected 0", vga_on); end
    pwon_reset = 1'b0;
    tick();
    n_cmp++; if (vga_on !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_recapture_vga: got %b expected 1", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_recapture_scan: got %b expected 1", scanlines_off); end
    we_low = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.sram_we_n !== 1'b1) we_low++;
    end
    n_cmp++; if (we_low != 0) begin n_bad++; $display("[TB] FAIL abort_no_retry: got %0d low cycles expected 0", we_low); end
  endtask

  task automatic test_reset_mid_write();
    int we_low;
    do_reset();
    boot(1'b1, 1'b0);
    bus.core_idle = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.sram_we_n !== 1'b1) begin n_bad++; $display("[TB] FAIL rmw_we_forced: got %b expected 1", bus.sram_we_n); end
    tick();
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_vga_on: got %b expected 0", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b1) begin n_bad++; $display("[TB] FAIL rmw_scanlines_off: got %b expected 1", scanlines_off); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_busy: got %b expected 0", busy); end
    n_cmp++; if (bus.core_wait !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_core_wait: got %b expected 0", bus.core_wait); end
    n_cmp++; if (bus.sram_addr !== DEF_ADDR) begin n_bad++; $display("[TB] FAIL rmw_addr_pass: got %h expected %h", bus.sram_addr, DEF_ADDR); end
    rst_n = 1'b1;
    we_low = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.sram_we_n !== 1'b1) we_low++;
    end
    n_cmp++; if (we_low != 0) begin n_bad++; $display("[TB] FAIL rmw_no_retry: got %0d low cycles expected 0", we_low); end
  endtask
`else
  task automatic test_no_writeback();
    int we_low, busy_hi, wait_hi;
    do_reset();
    boot(1'b0, 1'b1);
    bus.core_idle = 1'b1;
    pulse(1'b1, 1'b0);
    we_low = 0; busy_hi = 0; wait_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sram_we_n !== 1'b1) we_low++;
      if (busy !== 1'b0) busy_hi++;
      if (bus.core_wait !== 1'b0) wait_hi++;
    end
    n_cmp++; if (we_low != 0) begin n_bad++; $display("[TB] FAIL nowb_we_low: got %0d cycles expected 0", we_low); end
    n_cmp++; if (busy_hi != 0) begin n_bad++; $display("[TB] FAIL nowb_busy: got %0d cycles expected 0", busy_hi); end
    n_cmp++; if (wait_hi != 0) begin n_bad++; $display("[TB] FAIL nowb_core_wait: got %0d cycles expected 0", wait_hi); end
    n_cmp++; if (dirty !== 1'b1) begin n_bad++; $display("[TB] FAIL nowb_dirty_held: got %b expected 1", dirty); end
    n_cmp++; if (vga_on !== 1'b1) begin n_bad++; $display("[TB] FAIL nowb_vga_on: got %b expected 1", vga_on); end
    pulse(1'b1, 1'b1);
    n_cmp++; if (vga_on !== 1'b0) begin n_bad++; $display("[TB] FAIL nowb_both_vga: got %b expected 0", vga_on); end
    n_cmp++; if (scanlines_off !== 1'b0) begin n_bad++; $display("[TB] FAIL nowb_both_scan: got %b expected 0", scanlines_off); end
    bus.core_we_n = 1'b0;
    #1;
    n_cmp++; if (bus.sram_we_n !== 1'b0) begin n_bad++; $display("[TB] FAIL nowb_we_pass: got %b expected 0", bus.sram_we_n); end
    bus.core_we_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rst_n            = 1'b0;
    pwon_reset       = 1'b1;
    vga_on_in        = 1'b0;
    scanlines_off_in = 1'b0;
    toggle_vga       = 1'b0;
    toggle_scanlines = 1'b0;
    bus.core_addr    = DEF_ADDR;
    bus.core_we_n    = 1'b1;
    bus.core_oe_n    = 1'b0;
    bus.core_data    = DEF_DATA;
    bus.core_idle    = 1'b1;

    test_reset();
    test_boot_capture();
    test_passthrough();
    test_toggles();
`ifdef CFG_WRITEBACK_EN
    test_writeback();
    test_slot_wait();
    test_toggle_during_write();
    test_simultaneous();
    test_abort();
    test_reset_mid_write();
`else
    test_no_writeback();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
